int_alu_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle integer ALU. Accepts one integer uop per cycle through a valid/ready handshake. Carries the result through `STAGES` register stages to writeback, squashing in-flight uops younger than an invalidation point. Resolves branches one cycle after acceptance, independent of pipeline depth, so misprediction recovery stays fast while the result path is retimed for frequency.

---
 rtl/int_alu_pipe.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_int_alu_pipe.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_alu_pipe.sv
// ---------------------------------------------------------------------------
// int_alu_pipe
//
// Pipelined integer ALU. One uop is accepted per cycle. Its result is computed
// combinationally at acceptance and then carried through STAGES register
// stages to writeback. Branches and jumps are resolved at acceptance and
// reported one cycle later, whatever the pipeline depth.
//
// Optional feature: define INT_ALU_BITMANIP_EN to add the bit-manipulation
// opcodes (clz/ctz/cpop, min/max, sign/zero extension, orc.b, rev8).
// Without it those opcodes are illegal (result 0, flags 3).
//
// Handshake: a uop is taken on a rising edge when IN_valid && OUT_ready and
// it is not squashed by a same-cycle invalidate. OUT_ready drops only while
// the head stage holds a valid record and IN_wbStall is high. Writeback takes
// the record on any edge where OUT_valid && !IN_wbStall. While stalled every
// stage holds, but squashed records are still cleared.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   IN_valid .. IN_branchPred  uop fields (opcode, operands, pc, tags, sqN)
//   IN_invalidate(SqN)       squash everything younger than IN_invalidateSqN
//   IN_wbStall               writeback cannot accept this cycle
//   OUT_ready                pipeline advances this cycle
//   OUT_valid .. OUT_flags   writeback record (head stage)
//   OUT_branch*              one-cycle branch resolution pulse + redirect
// ---------------------------------------------------------------------------
module int_alu_pipe #(
    parameter int XLEN   = 32,
    parameter int SQN_W  = 6,
    parameter int TAG_W  = 6,
    parameter int ID_W   = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_valid,
    input  logic [5:0]       IN_opcode,
    input  logic [XLEN-1:0]  IN_srcA,
    input  logic [XLEN-1:0]  IN_srcB,
    input  logic [XLEN-1:0]  IN_imm,
    input  logic [XLEN-1:0]  IN_pc,
    input  logic [TAG_W-1:0] IN_tagDst,
    input  logic [4:0]       IN_nmDst,
    input  logic [SQN_W-1:0] IN_sqN,
    input  logic [ID_W-1:0]  IN_fetchID,
    input  logic             IN_branchPred,
    input  logic             IN_invalidate,
    input  logic [SQN_W-1:0] IN_invalidateSqN,
    input  logic             IN_wbStall,
    output logic             OUT_ready,
    output logic             OUT_valid,
    output logic [XLEN-1:0]  OUT_result,
    output logic [TAG_W-1:0] OUT_tagDst,
    output logic [4:0]       OUT_nmDst,
    output logic [SQN_W-1:0] OUT_sqN,
    output logic [1:0]       OUT_flags,
    output logic             OUT_branchValid,
    output logic             OUT_branchTaken,
    output logic             OUT_branchMispred,
    output logic             OUT_branchIsJump,
    output logic [XLEN-1:0]  OUT_branchAddress,
    output logic [SQN_W-1:0] OUT_branchSqN,
    output logic [ID_W-1:0]  OUT_branchID
);

    localparam int SH_W = $clog2(XLEN);

    // Modular age compare: sqn is strictly younger than inv_sqn when the
    // difference, read as a signed SQN_W-bit number, is positive.
    function automatic logic is_younger(input logic [SQN_W-1:0] sqn,
                                        input logic [SQN_W-1:0] inv_sqn);
        logic [SQN_W-1:0] diff;
        diff = sqn - inv_sqn;
        return (diff != '0) && !diff[SQN_W-1];
    endfunction

`ifdef INT_ALU_BITMANIP_EN
    function automatic logic [XLEN-1:0] f_clz(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + XLEN'(1);
            end
        end
        return n;
    endfunction

    function automatic logic [XLEN-1:0] f_ctz(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + XLEN'(1);
            end
        end
        return n;
    endfunction

    function automatic logic [XLEN-1:0] f_cpop(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] n;
        n = '0;
        for (int i = 0; i < XLEN; i++) n = n + {{(XLEN-1){1'b0}}, v[i]};
        return n;
    endfunction

    function automatic logic [XLEN-1:0] f_orcb(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int b = 0; b < XLEN / 8; b++) r[8*b +: 8] = (|v[8*b +: 8]) ? 8'hFF : 8'h00;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] f_rev8(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int b = 0; b < XLEN / 8; b++) r[8*b +: 8] = v[XLEN-8-8*b +: 8];
        return r;
    endfunction
`endif

    // ---------------------------------------------------------------- ALU
    logic [XLEN-1:0] alu_res;
    logic [1:0]      alu_flags;
    logic [XLEN-1:0] pc_plus4;
    logic [SH_W-1:0] shamt;
    logic            lt_s, lt_u, eq;

    assign pc_plus4 = IN_pc + XLEN'(4);
    assign shamt    = IN_srcB[SH_W-1:0];
    assign lt_s     = $signed(IN_srcA) < $signed(IN_srcB);
    assign lt_u     = IN_srcA < IN_srcB;
    assign eq       = IN_srcA == IN_srcB;

    always_comb begin
        alu_res   = '0;
        alu_flags = 2'd0;
        case (IN_opcode)
            6'd0, 6'd17: alu_res = IN_srcA + IN_srcB;
            6'd1:        alu_res = IN_srcA ^ IN_srcB;
            6'd2:        alu_res = IN_srcA | IN_srcB;
            6'd3:        alu_res = IN_srcA & IN_srcB;
            6'd4:        alu_res = IN_srcA << shamt;
            6'd5:        alu_res = IN_srcA >> shamt;
            6'd9:        alu_res = $signed(IN_srcA) >>> shamt;
            6'd6:        alu_res = {{(XLEN-1){1'b0}}, lt_s};
            6'd7:        alu_res = {{(XLEN-1){1'b0}}, lt_u};
            6'd8:        alu_res = IN_srcA - IN_srcB;
            6'd16:       alu_res = IN_srcB;
            6'd18, 6'd19: alu_res = pc_plus4;
            6'd20:       alu_flags = IN_imm[0] ? 2'd1 : 2'd2;
            6'd21:       alu_flags = 2'd3;
            6'd22:       alu_res = (IN_srcA << 1) + IN_srcB;
            6'd23:       alu_res = (IN_srcA << 2) + IN_srcB;
            6'd24:       alu_res = (IN_srcA << 3) + IN_srcB;
            6'd25:       alu_res = ~(IN_srcA ^ IN_srcB);
            6'd26:       alu_res = IN_srcA & ~IN_srcB;
            6'd27:       alu_res = IN_srcA | ~IN_srcB;
            // Conditional branches write nothing useful; resolution goes out
            // on the branch port.
            6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15: alu_res = '0;
`ifdef INT_ALU_BITMANIP_EN
            6'd28:       alu_res = f_clz(IN_srcA);
            6'd29:       alu_res = f_ctz(IN_srcA);
            6'd30:       alu_res = f_cpop(IN_srcA);
            6'd31:       alu_res = lt_s ? IN_srcB : IN_srcA;
            6'd32:       alu_res = lt_u ? IN_srcB : IN_srcA;
            6'd33:       alu_res = lt_s ? IN_srcA : IN_srcB;
            6'd34:       alu_res = lt_u ? IN_srcA : IN_srcB;
            6'd35:       alu_res = {{(XLEN-8){IN_srcA[7]}}, IN_srcA[7:0]};
            6'd36:       alu_res = {{(XLEN-16){IN_srcA[15]}}, IN_srcA[15:0]};
            6'd37:       alu_res = {{(XLEN-16){1'b0}}, IN_srcA[15:0]};
            6'd40:       alu_res = f_orcb(IN_srcA);
            6'd41:       alu_res = f_rev8(IN_srcA);
`endif
            default:     alu_flags = 2'd3;
        endcase
    end

    // ------------------------------------------------- branch evaluation
    logic            br_op, br_jump, br_taken, br_mispred;
    logic [XLEN-1:0] br_addr;
    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = IN_srcB + IN_imm;

    always_comb begin
        br_op    = 1'b0;
        br_jump  = 1'b0;
        br_taken = 1'b0;
        case (IN_opcode)
            6'd10: begin br_op = 1'b1; br_taken = eq;    end
            6'd11: begin br_op = 1'b1; br_taken = !eq;   end
            6'd12: begin br_op = 1'b1; br_taken = lt_s;  end
            6'd13: begin br_op = 1'b1; br_taken = !lt_s; end
            6'd14: begin br_op = 1'b1; br_taken = lt_u;  end
            6'd15: begin br_op = 1'b1; br_taken = !lt_u; end
            6'd18, 6'd19: begin br_op = 1'b1; br_jump = 1'b1; br_taken = 1'b1; end
            default: ;
        endcase
        // jalr target is never predicted, so it always redirects.
        if (IN_opcode == 6'd19) begin
            br_mispred = 1'b1;
            br_addr    = {jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            br_mispred = br_taken != IN_branchPred;
            br_addr    = br_taken ? IN_imm : pc_plus4;
        end
    end

    // ---------------------------------------------------------- pipeline
    logic [STAGES-1:0] valid_q, valid_d, alive;
    logic [XLEN-1:0]   result_q [STAGES];
    logic [TAG_W-1:0]  tag_q    [STAGES];
    logic [4:0]        nm_q     [STAGES];
    logic [SQN_W-1:0]  sqn_q    [STAGES];
    logic [1:0]        flags_q  [STAGES];
    logic              accept;

    assign OUT_ready = !(valid_q[STAGES-1] && IN_wbStall);
    assign accept    = IN_valid && OUT_ready
                       && !(IN_invalidate && is_younger(IN_sqN, IN_invalidateSqN));

    always_comb begin
        alive   = '0;
        valid_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            alive[i] = valid_q[i] && !(IN_invalidate && is_younger(sqn_q[i], IN_invalidateSqN));
        end
        valid_d[0] = OUT_ready ? accept : alive[0];
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = OUT_ready ? alive[i-1] : alive[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // Record payload is not reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (OUT_ready) begin
            result_q[0] <= alu_res;
            tag_q[0]    <= IN_tagDst;
            nm_q[0]     <= IN_nmDst;
            sqn_q[0]    <= IN_sqN;
            flags_q[0]  <= alu_flags;
            for (int i = 1; i < STAGES; i++) begin
                result_q[i] <= result_q[i-1];
                tag_q[i]    <= tag_q[i-1];
                nm_q[i]     <= nm_q[i-1];
                sqn_q[i]    <= sqn_q[i-1];
                flags_q[i]  <= flags_q[i-1];
            end
        end
    end

    assign OUT_valid  = valid_q[STAGES-1];
    assign OUT_result = result_q[STAGES-1];
    assign OUT_tagDst = tag_q[STAGES-1];
    assign OUT_nmDst  = nm_q[STAGES-1];
    assign OUT_sqN    = sqn_q[STAGES-1];
    assign OUT_flags  = flags_q[STAGES-1];

    // --------------------------------------------- branch result register
    // Pulse bits are rewritten every cycle so a stall never stretches them.
    logic            br_valid_q, br_taken_q, br_mispred_q;
    logic            br_valid_d, br_taken_d, br_mispred_d;
    logic            br_jump_q;
    logic [XLEN-1:0] br_addr_q;
    logic [SQN_W-1:0] br_sqn_q;
    logic [ID_W-1:0] br_id_q;

    assign br_valid_d   = accept && br_op;
    assign br_taken_d   = br_valid_d && br_taken;
    assign br_mispred_d = br_valid_d && br_mispred;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_valid_q   <= 1'b0;
            br_taken_q   <= 1'b0;
            br_mispred_q <= 1'b0;
        end else begin
            br_valid_q   <= br_valid_d;
            br_taken_q   <= br_taken_d;
            br_mispred_q <= br_mispred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (br_valid_d) begin
            br_jump_q <= br_jump;
            br_addr_q <= br_addr;
            br_sqn_q  <= IN_sqN;
            br_id_q   <= IN_fetchID;
        end
    end

    assign OUT_branchValid   = br_valid_q;
    assign OUT_branchTaken   = br_taken_q;
    assign OUT_branchMispred = br_mispred_q;
    assign OUT_branchIsJump  = br_jump_q;
    assign OUT_branchAddress = br_addr_q;
    assign OUT_branchSqN     = br_sqn_q;
    assign OUT_branchID      = br_id_q;

endmodule

// File: tb/tb_int_alu_pipe.sv
// Testbench for int_alu_pipe (XLEN=32, STAGES=2): scoreboard of expected
// writeback records plus per-cycle branch pulse checks.
module tb_int_alu_pipe;

    localparam int XLEN   = 32;
    localparam int SQN_W  = 6;
    localparam int TAG_W  = 6;
    localparam int ID_W   = 6;
    localparam int STAGES = 2;
    localparam int EW     = 2 + SQN_W + TAG_W + 5 + XLEN;

    // ---------------------------------------------------- clock / reset
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic             IN_valid;
    logic [5:0]       IN_opcode;
    logic [XLEN-1:0]  IN_srcA, IN_srcB, IN_imm, IN_pc;
    logic [TAG_W-1:0] IN_tagDst;
    logic [4:0]       IN_nmDst;
    logic [SQN_W-1:0] IN_sqN;
    logic [ID_W-1:0]  IN_fetchID;
    logic             IN_branchPred;
    logic             IN_invalidate;
    logic [SQN_W-1:0] IN_invalidateSqN;
    logic             IN_wbStall;
    logic             OUT_ready, OUT_valid;
    logic [XLEN-1:0]  OUT_result;
    logic [TAG_W-1:0] OUT_tagDst;
    logic [4:0]       OUT_nmDst;
    logic [SQN_W-1:0] OUT_sqN;
    logic [1:0]       OUT_flags;
    logic             OUT_branchValid, OUT_branchTaken, OUT_branchMispred, OUT_branchIsJump;
    logic [XLEN-1:0]  OUT_branchAddress;
    logic [SQN_W-1:0] OUT_branchSqN;
    logic [ID_W-1:0]  OUT_branchID;

    int_alu_pipe #(
        .XLEN(XLEN), .SQN_W(SQN_W), .TAG_W(TAG_W), .ID_W(ID_W), .STAGES(STAGES)
    ) dut (
        .clk(clk), .rst(rst),
        .IN_valid(IN_valid), .IN_opcode(IN_opcode),
        .IN_srcA(IN_srcA), .IN_srcB(IN_srcB), .IN_imm(IN_imm), .IN_pc(IN_pc),
        .IN_tagDst(IN_tagDst), .IN_nmDst(IN_nmDst), .IN_sqN(IN_sqN),
        .IN_fetchID(IN_fetchID), .IN_branchPred(IN_branchPred),
        .IN_invalidate(IN_invalidate), .IN_invalidateSqN(IN_invalidateSqN),
        .IN_wbStall(IN_wbStall),
        .OUT_ready(OUT_ready), .OUT_valid(OUT_valid), .OUT_result(OUT_result),
        .OUT_tagDst(OUT_tagDst), .OUT_nmDst(OUT_nmDst), .OUT_sqN(OUT_sqN),
        .OUT_flags(OUT_flags),
        .OUT_branchValid(OUT_branchValid), .OUT_branchTaken(OUT_branchTaken),
        .OUT_branchMispred(OUT_branchMispred), .OUT_branchIsJump(OUT_branchIsJump),
        .OUT_branchAddress(OUT_branchAddress), .OUT_branchSqN(OUT_branchSqN),
        .OUT_branchID(OUT_branchID)
    );

    // ------------------------------------------------------- scoreboard
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc_cyc = 0;
    int last_pop_cyc = 0;
    logic [EW-1:0]    exp_q[$];
    logic             br_pend;
    logic [35:0]      br_exp;
    logic [SQN_W-1:0] br_exp_sqn;
    logic [ID_W-1:0]  br_exp_id;
    logic [SQN_W-1:0] next_sqn;
    bit               rnd_mode;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        int d;
        d = int'(a) - int'(b);
        if (d > 31)  d -= 64;
        if (d < -32) d += 64;
        return d > 0;
    endfunction

    // Reference ALU: {flags, result}
    function automatic logic [33:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm,
                                            input logic [31:0] pc);
        logic [31:0] r;
        logic [1:0]  f;
        r = 32'd0;
        f = 2'd0;
        case (op)
            0, 17: r = a + b;
            1:  r = a ^ b;
            2:  r = a | b;
            3:  r = a & b;
            4:  r = a << b[4:0];
            5:  r = a >> b[4:0];
            9:  r = $signed(a) >>> b[4:0];
            6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7:  r = (a < b) ? 32'd1 : 32'd0;
            8:  r = a - b;
            16: r = b;
            18, 19: r = pc + 32'd4;
            20: f = imm[0] ? 2'd1 : 2'd2;
            21: f = 2'd3;
            22: r = a * 2 + b;
            23: r = a * 4 + b;
            24: r = a * 8 + b;
            25: r = ~(a ^ b);
            26: r = a & ~b;
            27: r = a | ~b;
            10, 11, 12, 13, 14, 15: r = 32'd0;
`ifdef INT_ALU_BITMANIP_EN
            28: begin
                r = 32'd32;
                for (int i = 31; i >= 0; i--) if (a[i]) begin r = 32'(31 - i); break; end
            end
`endif
            default: f = 2'd3;
        endcase
        return {f, r};
    endfunction

    // Reference branch unit: {is_branch, taken, mispred, jump, address}
    function automatic logic [35:0] ref_br(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm,
                                           input logic [31:0] pc, input logic pred);
        logic isbr, tk, mp, jmp;
        logic [31:0] addr;
        isbr = 1'b1; tk = 1'b0; jmp = 1'b0;
        case (op)
            10: tk = (a == b);
            11: tk = (a != b);
            12: tk = ($signed(a) < $signed(b));
            13: tk = ($signed(a) >= $signed(b));
            14: tk = (a < b);
            15: tk = (a >= b);
            18, 19: begin tk = 1'b1; jmp = 1'b1; end
            default: isbr = 1'b0;
        endcase
        if (op == 19) begin
            mp = 1'b1;
            addr = (b + imm) & 32'hFFFF_FFFE;
        end else begin
            mp = (tk != pred);
            addr = tk ? imm : pc + 32'd4;
        end
        return {isbr, tk, mp, jmp, addr};
    endfunction

    // One clock cycle: check outputs at the falling edge, update the model,
    // then step past the rising edge.
    task automatic tick(output bit acc);
        logic [EW-1:0] e;
        logic [33:0]   m;
        logic [35:0]   b;
        logic          kill;
        if (rnd_mode) begin
            IN_wbStall       = ($urandom_range(0, 3) == 0);
            IN_invalidate    = ($urandom_range(0, 9) == 0);
            IN_invalidateSqN = next_sqn - SQN_W'($urandom_range(0, 3));
        end
        @(negedge clk);
        cyc++;
        if (OUT_valid && !IN_wbStall) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_wb", 64'(OUT_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wb_rec", 64'({OUT_flags, OUT_sqN, OUT_tagDst, OUT_nmDst, OUT_result}), 64'(e));
                last_pop_cyc = cyc;
            end
        end
        check_eq("br_valid", 64'(OUT_branchValid), 64'(br_pend));
        if (br_pend) begin
            check_eq("br_taken", 64'(OUT_branchTaken), 64'(br_exp[34]));
            check_eq("br_mispred", 64'(OUT_branchMispred), 64'(br_exp[33]));
            check_eq("br_jump", 64'(OUT_branchIsJump), 64'(br_exp[32]));
            check_eq("br_sqn", 64'(OUT_branchSqN), 64'(br_exp_sqn));
            check_eq("br_id", 64'(OUT_branchID), 64'(br_exp_id));
            if (br_exp[33]) check_eq("br_addr", 64'(OUT_branchAddress), 64'(br_exp[31:0]));
        end
        br_pend = 1'b0;
        if (IN_invalidate) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                e = exp_q[i];
                if (younger(e[48:43], IN_invalidateSqN)) exp_q.delete(i);
            end
        end
        kill = IN_invalidate && younger(IN_sqN, IN_invalidateSqN);
        acc  = IN_valid && OUT_ready && !kill;
        if (acc) begin
            m = ref_alu(IN_opcode, IN_srcA, IN_srcB, IN_imm, IN_pc);
            exp_q.push_back({m[33:32], IN_sqN, IN_tagDst, IN_nmDst, m[31:0]});
            last_acc_cyc = cyc;
            b = ref_br(IN_opcode, IN_srcA, IN_srcB, IN_imm, IN_pc, IN_branchPred);
            if (b[35]) begin
                br_pend    = 1'b1;
                br_exp     = b;
                br_exp_sqn = IN_sqN;
                br_exp_id  = IN_fetchID;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------- driver tasks
    task automatic set_uop(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] pc, input logic pred);
        IN_valid      = 1'b1;
        IN_opcode     = op;
        IN_srcA       = a;
        IN_srcB       = b;
        IN_imm        = imm;
        IN_pc         = pc;
        IN_branchPred = pred;
        IN_sqN        = next_sqn;
        IN_tagDst     = TAG_W'($urandom_range(0, 63));
        IN_nmDst      = 5'($urandom_range(0, 31));
        IN_fetchID    = ID_W'($urandom_range(0, 63));
    endtask

    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc, input logic pred);
        bit acc;
        int tries;
        set_uop(op, a, b, imm, pc, pred);
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 60) begin
            tick(acc);
            tries++;
        end
        if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
        IN_valid = 1'b0;
        next_sqn++;
    endtask

    task automatic offer_once(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        set_uop(op, a, b, 32'h0, 32'h0, 1'b0);
        tick(acc);
        IN_valid = 1'b0;
        next_sqn++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic drain();
        bit acc;
        int n;
        IN_wbStall    = 1'b0;
        IN_invalidate = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || br_pend) && n < 40) begin
            tick(acc);
            n++;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- stimulus
    initial begin
        int a1;
        logic [5:0] ops [28];
        logic [31:0] ra, rb;
        for (int i = 0; i < 28; i++) ops[i] = 6'(i);
        rst = 1'b0; rnd_mode = 1'b0; br_pend = 1'b0; next_sqn = '0;
        IN_valid = 0; IN_opcode = 0; IN_srcA = 0; IN_srcB = 0; IN_imm = 0; IN_pc = 0;
        IN_tagDst = 0; IN_nmDst = 0; IN_sqN = 0; IN_fetchID = 0; IN_branchPred = 0;
        IN_invalidate = 0; IN_invalidateSqN = 0; IN_wbStall = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(OUT_valid), 64'd0);
        check_eq("rst_br_valid", 64'(OUT_branchValid), 64'd0);
        check_eq("rst_br_taken", 64'(OUT_branchTaken), 64'd0);
        check_eq("rst_br_mispred", 64'(OUT_branchMispred), 64'd0);
        check_eq("rst_ready", 64'(OUT_ready), 64'd1);
        rst = 1'b1;

        // Basic: add 5+7, visible STAGES edges after acceptance.
        send(6'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0);
        a1 = last_acc_cyc;
        idle(1);
        check_eq("add_out", 64'({OUT_valid, OUT_flags, OUT_result}), 64'({1'b1, 2'b00, 32'd12}));
        drain();
        check_eq("add_latency", 64'(last_pop_cyc - a1), 64'(STAGES));

        // Back-to-back at full throughput.
        send(6'd1, 32'hF0F0_1234, 32'h0FF0_4321, 0, 0, 0);
        a1 = last_acc_cyc;
        send(6'd8, 32'd3, 32'd10, 0, 0, 0);
        send(6'd9, 32'h8000_0000, 32'd4, 0, 0, 0);
        check_eq("b2b_accepts", 64'(last_acc_cyc - a1), 64'd2);
        drain();

        // Opcode sweep incl. special-flag and illegal codes.
        for (int i = 0; i < 28; i++) send(ops[i], $urandom, $urandom, $urandom, $urandom, 1'b0);
        send(6'd20, 0, 0, 32'd1, 0, 0);
        send(6'd20, 0, 0, 32'd2, 0, 0);
        send(6'd50, 32'd1, 32'd2, 0, 0, 0);
        send(6'd63, 32'd1, 32'd2, 0, 0, 0);
        drain();

        // Configuration opcode: clz.
        send(6'd28, 32'h0000_8000, 32'd0, 0, 0, 0);
        idle(1);
`ifdef INT_ALU_BITMANIP_EN
        check_eq("clz_out", 64'({OUT_flags, OUT_result}), 64'({2'd0, 32'd16}));
`else
        check_eq("clz_out", 64'({OUT_flags, OUT_result}), 64'({2'd3, 32'd0}));
`endif
        drain();

        // Stall hold: head held three cycles, then the queue drains in order.
        send(6'd0, 32'd1, 32'd1, 0, 0, 0);
        send(6'd0, 32'd2, 32'd2, 0, 0, 0);
        send(6'd0, 32'd3, 32'd3, 0, 0, 0);
        IN_wbStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check_eq("stall_ready", 64'(OUT_ready), 64'd0);
            check_eq("stall_hold", 64'({OUT_valid, OUT_flags, OUT_sqN, OUT_tagDst, OUT_nmDst, OUT_result}),
                     64'({1'b1, exp_q[0]}));
        end
        drain();

        // Squash: 3 survives, 4 killed in flight, 5 (a beq) killed at acceptance.
        next_sqn = 6'd3;
        send(6'd0, 32'd30, 32'd3, 0, 0, 0);
        send(6'd0, 32'd40, 32'd4, 0, 0, 0);
        IN_invalidate = 1'b1; IN_invalidateSqN = 6'd3;
        offer_once(6'd10, 32'd5, 32'd5);
        IN_invalidate = 1'b0;
        drain();

        // Wrap-around kill during a stall: 62 kept, 1 killed.
        next_sqn = 6'd62;
        send(6'd0, 32'd62, 32'd0, 0, 0, 0);
        next_sqn = 6'd1;
        send(6'd0, 32'd1, 32'd0, 0, 0, 0);
        IN_wbStall = 1'b1; IN_invalidate = 1'b1; IN_invalidateSqN = 6'd63;
        idle(1);
        IN_invalidate = 1'b0;
        check_eq("wrap_head_kept", 64'({OUT_valid, OUT_sqN}), 64'({1'b1, 6'd62}));
        drain();

        // Killed head frees the pipeline even with the stall still high.
        next_sqn = 6'd10;
        send(6'd0, 32'd10, 32'd0, 0, 0, 0);
        IN_wbStall = 1'b1;
        idle(1);
        IN_invalidate = 1'b1; IN_invalidateSqN = 6'd8;
        idle(1);
        IN_invalidate = 1'b0;
        check_eq("killed_head_valid", 64'(OUT_valid), 64'd0);
        check_eq("killed_head_ready", 64'(OUT_ready), 64'd1);
        drain();

        // Branch resolution.
        send(6'd11, 32'd1, 32'd2, 32'h200, 32'h100, 1'b0);
        check_eq("bne_res", 64'({OUT_branchValid, OUT_branchTaken, OUT_branchMispred, OUT_branchAddress}),
                 64'({3'b111, 32'h200}));
        send(6'd10, 32'd1, 32'd2, 32'h200, 32'h100, 1'b1);
        check_eq("beq_res", 64'({OUT_branchValid, OUT_branchTaken, OUT_branchMispred, OUT_branchAddress}),
                 64'({3'b101, 32'h104}));
        send(6'd19, 32'd0, 32'h301, 32'h0, 32'h100, 1'b0);
        check_eq("jalr_res", 64'({OUT_branchValid, OUT_branchMispred, OUT_branchIsJump, OUT_branchAddress}),
                 64'({3'b111, 32'h300}));
        drain();

        // Random traffic with stalls and invalidations.
        rnd_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            send(ops[$urandom_range(0, 27)], ra, rb, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        rnd_mode = 1'b0;
        drain();

        // Reset with two uops in flight.
        send(6'd0, 32'd8, 32'd9, 0, 0, 0);
        send(6'd18, 32'd0, 32'd0, 32'h400, 32'h10, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(OUT_valid), 64'd0);
        check_eq("midrst_br_valid", 64'(OUT_branchValid), 64'd0);
        check_eq("midrst_br_mispred", 64'(OUT_branchMispred), 64'd0);
        exp_q.delete();
        br_pend = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(5);
        check_eq("post_rst_valid", 64'(OUT_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
